// File: rtl/spram_arbiter_if.sv
// Requester-side and SPRAM-side signal bundle for spram_arbiter.
// The slave modport is the arbiter. The master modport is the environment: requesters plus the SPRAM.
interface spram_arbiter_if;
    logic        p0_req;
    logic        p1_req;
    logic        p0_we;
    logic        p1_we;
    logic [13:0] p0_addr;
    logic [13:0] p1_addr;
    logic [15:0] p0_wdata;
    logic [15:0] p1_wdata;
    logic        p0_gnt;
    logic        p1_gnt;
    logic [15:0] p0_rdata;
    logic [15:0] p1_rdata;
    logic        p0_rvalid;
    logic        p1_rvalid;
    logic [13:0] ram_addr;
    logic [15:0] ram_data_in;
    logic        ram_we;
    logic [15:0] ram_data_out;

    modport slave (
        input  p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
        input  p0_wdata, p1_wdata, ram_data_out,
        output p0_gnt, p1_gnt, p0_rdata, p1_rdata, p0_rvalid, p1_rvalid,
        output ram_addr, ram_data_in, ram_we
    );

    modport master (
        output p0_req, p1_req, p0_we, p1_we, p0_addr, p1_addr,
        output p0_wdata, p1_wdata, ram_data_out,
        input  p0_gnt, p1_gnt, p0_rdata, p1_rdata, p0_rvalid, p1_rvalid,
        input  ram_addr, ram_data_in, ram_we
    );
endinterface

// File: rtl/spram_arbiter.sv
// Two-port arbiter in front of a single-port RAM. Grants are zero-wait. Read data returns one cycle after the grant.
// Ties go round-robin, or to port 0 under a starvation cap that lets port 1 through.
module spram_arbiter #(
    parameter int          ROUND_ROBIN  = 1,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic           clk,
    input  logic           rst,
    spram_arbiter_if.slave bus
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic        last_q, last_d;     // 1: port 1 was granted most recently
    logic [3:0]  starve_q, starve_d;
    logic        rv0_q, rv1_q;
    logic [15:0] rd0_q, rd1_q;
    logic        gnt0, gnt1;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            if (bus.p0_req && !bus.p1_req) begin
                gnt0 = 1'b1;
            end else if (bus.p1_req && !bus.p0_req) begin
                gnt1 = 1'b1;
            end else if (bus.p0_req && bus.p1_req) begin
                if (ROUND_ROBIN != 0) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt1 = (starve_q == LIMIT);
                    gnt0 = !gnt1;
                end
            end
        end
    end

    always_comb begin
        last_d   = last_q;
        starve_d = starve_q;
        if (gnt0) begin
            last_d = 1'b0;
        end else if (gnt1) begin
            last_d = 1'b1;
        end
        if (!bus.p1_req || gnt1) begin
            starve_d = 4'd0;
        end else if (gnt0 && (starve_q < LIMIT)) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // Port 0 is presented to the RAM whenever nobody is granted.
    always_comb begin
        bus.ram_addr    = bus.p0_addr;
        bus.ram_data_in = bus.p0_wdata;
        bus.ram_we      = 1'b0;
        if (gnt1) begin
            bus.ram_addr    = bus.p1_addr;
            bus.ram_data_in = bus.p1_wdata;
            bus.ram_we      = bus.p1_we;
        end else if (gnt0) begin
            bus.ram_we = bus.p0_we;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q   <= 1'b1;
            starve_q <= 4'd0;
            rv0_q    <= 1'b0;
            rv1_q    <= 1'b0;
            rd0_q    <= 16'd0;
            rd1_q    <= 16'd0;
        end else begin
            last_q   <= last_d;
            starve_q <= starve_d;
            rv0_q    <= gnt0 && !bus.p0_we;
            rv1_q    <= gnt1 && !bus.p1_we;
            if (rv0_q) begin
                rd0_q <= bus.ram_data_out;
            end
            if (rv1_q) begin
                rd1_q <= bus.ram_data_out;
            end
        end
    end

    // Read data passes straight through in the rvalid cycle, then is held until the next rvalid.
    assign bus.p0_gnt    = gnt0;
    assign bus.p1_gnt    = gnt1;
    assign bus.p0_rvalid = rv0_q;
    assign bus.p1_rvalid = rv1_q;
    assign bus.p0_rdata  = rv0_q ? bus.ram_data_out : rd0_q;
    assign bus.p1_rdata  = rv1_q ? bus.ram_data_out : rd1_q;
endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: instance 0 is round-robin, instance 1 is fixed priority with a starvation limit of 4.
// A behavioural model of the grant rules and the RAM contents is checked every cycle, alongside hand-computed expectations.
module tb_spram_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    spram_arbiter_if bus [2] ();

    logic [1:0]  d_req  [2];
    logic [1:0]  d_we   [2];
    logic [13:0] d_addr [2][2];
    logic [15:0] d_wd   [2][2];
    logic [1:0]  o_gnt  [2];
    logic [1:0]  o_rv   [2];
    logic [15:0] o_rd   [2][2];
    logic        o_we   [2];
    logic [13:0] o_addr [2];
    logic [15:0] o_din  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic [15:0] mem [16384];

        assign bus[g].p0_req   = d_req[g][0];
        assign bus[g].p1_req   = d_req[g][1];
        assign bus[g].p0_we    = d_we[g][0];
        assign bus[g].p1_we    = d_we[g][1];
        assign bus[g].p0_addr  = d_addr[g][0];
        assign bus[g].p1_addr  = d_addr[g][1];
        assign bus[g].p0_wdata = d_wd[g][0];
        assign bus[g].p1_wdata = d_wd[g][1];
        assign o_gnt[g]   = {bus[g].p1_gnt, bus[g].p0_gnt};
        assign o_rv[g]    = {bus[g].p1_rvalid, bus[g].p0_rvalid};
        assign o_rd[g][0] = bus[g].p0_rdata;
        assign o_rd[g][1] = bus[g].p1_rdata;
        assign o_we[g]    = bus[g].ram_we;
        assign o_addr[g]  = bus[g].ram_addr;
        assign o_din[g]   = bus[g].ram_data_in;

        spram_arbiter #(.ROUND_ROBIN(g == 0 ? 1 : 0), .STARVE_LIMIT(LIMIT)) u_dut (
            .clk(clk),
            .rst(rst),
            .bus(bus[g])
        );

        initial begin
            for (int a = 0; a < 16384; a++) mem[a] <= 16'(a) ^ 16'h5A5A;
        end

        always @(posedge clk) begin
            if (bus[g].ram_we) mem[bus[g].ram_addr] <= bus[g].ram_data_in;
            bus[g].ram_data_out <= mem[bus[g].ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;

    logic [15:0] mmem [2][16384];
    int          last   [2];
    int          streak [2];
    logic [1:0]  pend   [2];
    logic [15:0] pdat   [2][2];
    logic [15:0] hold   [2][2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_check();
        int         w;
        logic [1:0] eg;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                check($sformatf("i%0d rst gnt", i), 32'(o_gnt[i]), 0);
                check($sformatf("i%0d rst rvalid", i), 32'(o_rv[i]), 0);
                check($sformatf("i%0d rst rdata0", i), 32'(o_rd[i][0]), 0);
                check($sformatf("i%0d rst rdata1", i), 32'(o_rd[i][1]), 0);
                check($sformatf("i%0d rst ram_we", i), 32'(o_we[i]), 0);
                last[i] = 1; streak[i] = 0; pend[i] = 2'b00;
                hold[i][0] = 16'h0; hold[i][1] = 16'h0;
            end else begin
                for (int p = 0; p < 2; p++) if (pend[i][p]) hold[i][p] = pdat[i][p];
                check($sformatf("i%0d rvalid", i), 32'(o_rv[i]), 32'(pend[i]));
                check($sformatf("i%0d rdata0", i), 32'(o_rd[i][0]), 32'(hold[i][0]));
                check($sformatf("i%0d rdata1", i), 32'(o_rd[i][1]), 32'(hold[i][1]));
                if (d_req[i][0] && !d_req[i][1]) w = 0;
                else if (d_req[i][1] && !d_req[i][0]) w = 1;
                else if (!d_req[i][0]) w = -1;
                else if (i == 0) w = 1 - last[i];
                else w = (streak[i] >= LIMIT) ? 1 : 0;
                eg = (w < 0) ? 2'b00 : (w == 0 ? 2'b01 : 2'b10);
                check($sformatf("i%0d gnt", i), 32'(o_gnt[i]), 32'(eg));
                if (w < 0) begin
                    check($sformatf("i%0d idle ram_we", i), 32'(o_we[i]), 0);
                    check($sformatf("i%0d idle ram_addr", i), 32'(o_addr[i]), 32'(d_addr[i][0]));
                    check($sformatf("i%0d idle ram_din", i), 32'(o_din[i]), 32'(d_wd[i][0]));
                end else begin
                    check($sformatf("i%0d ram_we", i), 32'(o_we[i]), 32'(d_we[i][w]));
                    check($sformatf("i%0d ram_addr", i), 32'(o_addr[i]), 32'(d_addr[i][w]));
                    check($sformatf("i%0d ram_din", i), 32'(o_din[i]), 32'(d_wd[i][w]));
                end
                pend[i] = 2'b00;
                if (w >= 0) begin
                    if (d_we[i][w]) mmem[i][d_addr[i][w]] = d_wd[i][w];
                    else begin
                        pend[i][w] = 1'b1;
                        pdat[i][w] = mmem[i][d_addr[i][w]];
                    end
                    last[i] = w;
                end
                if (!d_req[i][1] || w == 1) streak[i] = 0;
                else if (w == 0 && streak[i] < LIMIT) streak[i]++;
            end
        end
    endtask

    task automatic half();
        @(negedge clk);
        model_check();
    endtask

    task automatic fin();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int p, input bit r, input bit we, input logic [13:0] a, input logic [15:0] wd);
        for (int i = 0; i < 2; i++) begin
            d_req[i][p] = r; d_we[i][p] = we; d_addr[i][p] = a; d_wd[i][p] = wd;
        end
    endtask

    logic [19:0] gseq [2];
    logic [1:0]  gs   [2];

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 14'h0, 16'h0);
        drive(1, 0, 0, 14'h0, 16'h0);
        for (int i = 0; i < 2; i++)
            for (int a = 0; a < 16384; a++) mmem[i][a] = 16'(a) ^ 16'h5A5A;
        repeat (2) begin half(); fin(); end
        rst = 1'b0;

        // Single p0 write, then read-back.
        drive(0, 1, 1, 14'h0010, 16'hBEEF);
        half();
        check("wr gnt", 32'(o_gnt[0]), 32'h1);
        check("wr ram_we", 32'(o_we[0]), 32'h1);
        check("wr ram_addr", 32'(o_addr[0]), 32'h0010);
        fin();
        drive(0, 1, 0, 14'h0010, 16'h0);
        half(); fin();
        drive(0, 0, 0, 14'h0010, 16'h0);
        half();
        check("rd rvalid", 32'(o_rv[0]), 32'h1);
        check("rd rdata", 32'(o_rd[0][0]), 32'hBEEF);
        fin();

        // Fresh reset, then both ports read continuously.
        rst = 1'b1; half(); fin(); rst = 1'b0;
        drive(0, 1, 0, 14'h0100, 16'h0);
        drive(1, 1, 0, 14'h0200, 16'h0);
        gseq[0] = '0; gseq[1] = '0;
        for (int c = 0; c < 10; c++) begin
            half();
            for (int i = 0; i < 2; i++) begin
                gseq[i] = {gseq[i][17:0], o_gnt[i]};
                gs[i] = o_gnt[i];
            end
            fin();
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++) if (gs[i][p]) d_addr[i][p] = d_addr[i][p] + 14'd1;
        end
        check("rr grant pattern", 32'(gseq[0]), 32'h66666);
        check("fixed grant pattern", 32'(gseq[1]), 32'h55956);
        drive(0, 0, 0, 14'h0, 16'h0);
        drive(1, 0, 0, 14'h0, 16'h0);
        half(); fin();
        half(); fin();

        // p1 writes the top address, p0 reads it back next cycle.
        drive(1, 1, 1, 14'h3FFF, 16'h1234);
        half();
        check("top wr gnt", 32'(o_gnt[0]), 32'h2);
        check("top wr addr", 32'(o_addr[0]), 32'h3FFF);
        fin();
        drive(1, 0, 0, 14'h0, 16'h0);
        drive(0, 1, 0, 14'h3FFF, 16'h0);
        half();
        check("top p1 rvalid a", 32'(o_rv[0][1]), 32'h0);
        fin();
        drive(0, 0, 0, 14'h0, 16'h0);
        half();
        check("top p0 rvalid", 32'(o_rv[0][0]), 32'h1);
        check("top p0 rdata", 32'(o_rd[0][0]), 32'h1234);
        check("top p1 rvalid b", 32'(o_rv[0][1]), 32'h0);
        fin();

        // Reset right after a p1 read completes; hold a tie through it.
        drive(1, 1, 0, 14'h0020, 16'h0);
        half(); fin();
        rst = 1'b1;
        drive(0, 1, 1, 14'h0030, 16'hAAAA);
        drive(1, 1, 0, 14'h0021, 16'h0);
        half();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d rstpulse gnt", i), 32'(o_gnt[i]), 32'h0);
            check($sformatf("i%0d rstpulse ram_we", i), 32'(o_we[i]), 32'h0);
            check($sformatf("i%0d rstpulse p1 rvalid", i), 32'(o_rv[i][1]), 32'h0);
        end
        fin();
        rst = 1'b0;
        half();
        for (int i = 0; i < 2; i++) begin
            check($sformatf("i%0d post-rst p1 rvalid", i), 32'(o_rv[i][1]), 32'h0);
            check($sformatf("i%0d post-rst tie", i), 32'(o_gnt[i]), 32'h1);
        end
        fin();

        // Random traffic; requesters hold their request until granted.
        for (int c = 0; c < 400; c++) begin
            half();
            gs[0] = o_gnt[0];
            gs[1] = o_gnt[1];
            fin();
            for (int i = 0; i < 2; i++)
                for (int p = 0; p < 2; p++)
                    if (!d_req[i][p] || gs[i][p]) begin
                        d_req[i][p]  = ($urandom_range(0, 3) != 0);
                        d_we[i][p]   = 1'($urandom_range(0, 1));
                        d_addr[i][p] = ($urandom_range(0, 9) == 0) ? 14'h3FFF : 14'($urandom_range(0, 7));
                        d_wd[i][p]   = 16'($urandom);
                    end
        end
        drive(0, 0, 0, 14'h0, 16'h0);
        drive(1, 0, 0, 14'h0, 16'h0);
        repeat (2) begin half(); fin(); end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spram_arbiter.md
SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 The block SHALL have parameter ROUND_ROBIN, default 1: 1 selects round-robin, 0 selects fixed priority for port 0.
REQ-002 The block SHALL have parameter STARVE_LIMIT, default 4: maximum consecutive port-0 grants while port 1 waits, fixed mode only, legal range 1..15.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 p0_req, p1_req  input  1 each  access request (p0 = CPU, p1 = video/DMA).
REQ-006 p0_we, p1_we  input  1 each  1 = write, 0 = read.
REQ-007 p0_addr, p1_addr  input  14 each  word address.
REQ-008 p0_wdata, p1_wdata  input  16 each  write data.
REQ-009 p0_gnt, p1_gnt  output  1 each  request accepted this cycle.
REQ-010 p0_rdata, p1_rdata  output  16 each  read data.
REQ-011 p0_rvalid, p1_rvalid  output  1 each  read data valid.
REQ-012 ram_addr  output  14  to SPRAM ADDRESS.
REQ-013 ram_data_in  output  16  to SPRAM DATAIN.
REQ-014 ram_we  output  1  to SPRAM WREN/MASKWREN.
REQ-015 ram_data_out  input  16  from SPRAM DATAOUT; valid one cycle after a read address is clocked.

Function
REQ-016 A transfer SHALL complete on a rising edge where pX_req and pX_gnt are both 1.
  - Requesters hold req/we/addr/wdata stable until granted.
REQ-017 At most one gnt SHALL be high in any cycle.
  - gnt is combinational from the current req values and registered arbiter state, so a single pending request is granted in the cycle it is raised (zero-wait).
REQ-018 When exactly one port requests, that port SHALL be granted regardless of pointer or counter state.
REQ-019 Round-robin mode, both requesting: the port not granted most recently SHALL win.
  - last_grant register updates only on completed transfers.
  - last_grant resets to port 1, so port 0 wins the first tie.
REQ-020 Fixed mode, both requesting: port 0 SHALL win, except when starve_cnt == STARVE_LIMIT, in which case port 1 SHALL win.
REQ-021 starve_cnt (4 bits) behaviour:
  - increments on each port-0 grant while p1_req is high;
  - clears on any port-1 grant or any cycle with p1_req low;
  - never exceeds STARVE_LIMIT.
REQ-022 RAM side, granted port: ram_addr, ram_data_in and ram_we SHALL be that port's addr, wdata and (we AND gnt).
REQ-023 RAM side, no grant: ram_we SHALL be 0, and ram_addr/ram_data_in SHALL be port 0's addr/wdata.
REQ-024 On a completed read by port X, pX_rvalid SHALL be 1 in exactly the following cycle, with pX_rdata = ram_data_out in that cycle.
  - pX_rdata holds its value until the next pX_rvalid.
  - Read latency is 1 cycle.
REQ-025 Completed writes SHALL produce no rvalid; a write takes one cycle.
REQ-026 Back-to-back access rules:
  - One port may complete one access per cycle, with no bubble.
  - A read completing in the same cycle as the other port's rvalid is legal.
  - Interleaved reads keep each port's rvalid/rdata pairing correct.
REQ-027 Same-address write by one port followed next cycle by a read by the other port SHALL return the newly written data.
  - No forwarding is needed; the SPRAM provides this ordering.
REQ-028 Address and data pass through unchanged: no wrap or arithmetic is applied to the 14-bit address.
  - Address 16383 is accessed as-is.

Reset
REQ-029 While rst = 1, the block SHALL force:
  - p0_gnt = p1_gnt = 0;
  - p0_rvalid = p1_rvalid = 0;
  - p0_rdata = p1_rdata = 0;
  - ram_we = 0;
  - last_grant = port 1;
  - starve_cnt = 0.
REQ-030 A read completed in the cycle rst asserts SHALL produce no rvalid after reset.
  - Arbitration resumes on the first rising edge with rst = 0.

Verification
REQ-031 p0 writes 0xBEEF to 0x0010 while p1 is idle -> p0_gnt = 1 the same cycle, ram_we = 1, ram_addr = 0x0010; a p0 read of 0x0010 next cycle gives p0_rvalid = 1 one cycle later with p0_rdata = 0xBEEF.
REQ-032 ROUND_ROBIN = 1, both reading every cycle for 6 cycles after reset -> grants alternate p0,p1,p0,p1,p0,p1, and each rvalid carries the data of its own address.
REQ-033 ROUND_ROBIN = 0, STARVE_LIMIT = 4, both requesting continuously -> grant pattern p0 x4, p1 x1, repeating.
REQ-034 p1 writes 0x1234 to 0x3FFF, then p0 reads 0x3FFF the next cycle -> p0_rdata = 0x1234, and p1_rvalid stays 0 throughout.
REQ-035 rst pulsed high for 1 cycle in the cycle after p1's read completes -> p1_rvalid = 0, all gnt = 0 and ram_we = 0 during reset; the first tie after reset is granted to p0.
